mem_access_unit: RTL and testbench

//  MEM-stage load/store unit that produces the memory data and stall that the MEM/WB register consumes.
//  - Turns EX/MEM control (read/write, size, sign) into a handshaked data-memory bus transaction.
//  - Aligns big-endian byte lanes and extends load data.
//  - Holds the result stable until the pipeline advances.

---
 rtl/mem_access_unit.sv | 210 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit.
// Turns EX/MEM load/store control into a handshaked data-memory bus access.
// Drives big-endian byte lanes, extends load data, and holds the result until
// the pipeline advances.
// Optional LL/SC support is built when the macro MEM_LLSC_EN is defined.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 30
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  M_MemRead,
  input  logic                  M_MemWrite,
  input  logic                  M_MemByte,
  input  logic                  M_MemHalf,
  input  logic                  M_MemSignExtend,
  input  logic [31:0]           M_Address,
  input  logic [31:0]           M_WriteData,
  input  logic                  M_Flush,
  input  logic                  M_StallIn,
  input  logic                  M_LLSC,
  input  logic                  M_Eret,
  input  logic                  DataMem_Ready,
  input  logic [31:0]           DataMem_In,
  output logic                  DataMem_Read,
  output logic [3:0]            DataMem_Write,
  output logic [ADDR_WIDTH-1:0] DataMem_Address,
  output logic [31:0]           DataMem_Out,
  output logic [31:0]           M_ReadData,
  output logic                  M_MemStall,
  output logic                  M_Exc_AdEL,
  output logic                  M_Exc_AdES
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] rdata_q;
  logic        byte_q;
  logic        half_q;
  logic        sign_q;
  logic [1:0]  lane_q;
  logic        load_q;

  logic        word_acc;
  logic        misalign;
  logic        access;
  logic        req;

  // Big-endian lane enables: lane [3] is byte address 00.
  function automatic logic [3:0] lane_mask(input logic byt, input logic half,
                                           input logic [1:0] a);
    logic [3:0] m;
    if (byt) begin
      case (a)
        2'b00:   m = 4'b1000;
        2'b01:   m = 4'b0100;
        2'b10:   m = 4'b0010;
        default: m = 4'b0001;
      endcase
    end else if (half) begin
      m = a[1] ? 4'b0011 : 4'b1100;
    end else begin
      m = 4'b1111;
    end
    return m;
  endfunction

  // Right-justified store data replicated onto every candidate lane.
  function automatic logic [31:0] store_align(input logic byt, input logic half,
                                              input logic [31:0] d);
    logic [31:0] r;
    if (byt)       r = {4{d[7:0]}};
    else if (half) r = {2{d[15:0]}};
    else           r = d;
    return r;
  endfunction

  // Pick the addressed lane out of the read word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] din,
                                              input logic byt, input logic half,
                                              input logic sgn, input logic [1:0] a);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (a)
      2'b00:   b = din[31:24];
      2'b01:   b = din[23:16];
      2'b10:   b = din[15:8];
      default: b = din[7:0];
    endcase
    h = a[1] ? din[15:0] : din[31:16];
    if (byt)       r = sgn ? 32'(b) : {24'd0, b};
    else if (half) r = sgn ? 32'(h) : {16'd0, h};
    else           r = din;
    return r;
  endfunction

  assign word_acc   = ~M_MemByte & ~M_MemHalf;
  assign misalign   = (word_acc & (|M_Address[1:0])) |
                      (M_MemHalf & ~M_MemByte & M_Address[0]);
  assign M_Exc_AdEL = M_MemRead  & misalign & ~M_Flush;
  assign M_Exc_AdES = M_MemWrite & misalign & ~M_Flush;
  assign access     = (M_MemRead | M_MemWrite) & ~M_Flush & ~misalign;

`ifdef MEM_LLSC_EN
  logic                  ll_bit;
  logic [ADDR_WIDTH-1:0] ll_addr;
  logic                  ll_q;
  logic                  sc_q;
  logic                  sc_req;
  logic                  sc_fail;

  // A failing SC never touches the bus; it reports 0 right away.
  assign sc_req     = access & M_MemWrite & M_LLSC;
  assign sc_fail    = sc_req & ~(ll_bit & (ll_addr == M_Address[ADDR_WIDTH+1:2]));
  assign req        = access & ~sc_fail;
  assign M_ReadData = ((state == IDLE) && sc_fail) ? 32'd0 : rdata_q;

  // LL bit: set by a completed LL, cleared by any SC issued in IDLE and by ERET.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ll_bit  <= 1'b0;
      ll_addr <= '0;
    end else begin
      if (state == WAIT && DataMem_Ready && ll_q) begin
        ll_bit  <= 1'b1;
        ll_addr <= DataMem_Address;
      end
      if ((state == IDLE && sc_req) || M_Eret)
        ll_bit <= 1'b0;
    end
  end

  // Remember whether the issued access is an LL or an SC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ll_q <= 1'b0;
      sc_q <= 1'b0;
    end else if (state == IDLE && req) begin
      ll_q <= M_MemRead & M_LLSC;
      sc_q <= M_MemWrite & M_LLSC;
    end
  end
`else
  logic unused_llsc;
  assign unused_llsc = M_LLSC ^ M_Eret;
  assign req         = access;
  assign M_ReadData  = rdata_q;
`endif

  assign M_MemStall = (state == IDLE) ? req : (state == WAIT);

  // Access FSM: issue on the IDLE edge, wait for Ready, hold in DONE until MEM advances.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      DataMem_Read    <= 1'b0;
      DataMem_Write   <= 4'b0000;
      DataMem_Address <= '0;
      DataMem_Out     <= 32'd0;
      rdata_q         <= 32'd0;
      byte_q          <= 1'b0;
      half_q          <= 1'b0;
      sign_q          <= 1'b0;
      lane_q          <= 2'b00;
      load_q          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            state           <= WAIT;
            DataMem_Read    <= M_MemRead;
            DataMem_Write   <= M_MemWrite ? lane_mask(M_MemByte, M_MemHalf, M_Address[1:0])
                                          : 4'b0000;
            DataMem_Address <= M_Address[ADDR_WIDTH+1:2];
            DataMem_Out     <= store_align(M_MemByte, M_MemHalf, M_WriteData);
            byte_q          <= M_MemByte;
            half_q          <= M_MemHalf;
            sign_q          <= M_MemSignExtend;
            lane_q          <= M_Address[1:0];
            load_q          <= M_MemRead;
          end
        end
        WAIT: begin
          if (DataMem_Ready) begin
            state         <= DONE;
            DataMem_Read  <= 1'b0;
            DataMem_Write <= 4'b0000;
            if (load_q)
              rdata_q <= load_extend(DataMem_In, byte_q, half_q, sign_q, lane_q);
`ifdef MEM_LLSC_EN
            else if (sc_q)
              rdata_q <= 32'd1;
`endif
          end
        end
        DONE: begin
          if (!M_StallIn)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed, table-driven bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clock;
  logic        reset;
  logic        M_MemRead, M_MemWrite, M_MemByte, M_MemHalf, M_MemSignExtend;
  logic [31:0] M_Address, M_WriteData;
  logic        M_Flush, M_StallIn, M_LLSC, M_Eret;
  logic        DataMem_Ready;
  logic [31:0] DataMem_In;
  logic        DataMem_Read;
  logic [3:0]  DataMem_Write;
  logic [29:0] DataMem_Address;
  logic [31:0] DataMem_Out, M_ReadData;
  logic        M_MemStall, M_Exc_AdEL, M_Exc_AdES;

  int tests    = 0;
  int failures = 0;

  mem_access_unit #(.ADDR_WIDTH(30)) dut (
    .clock(clock), .reset(reset),
    .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_MemByte(M_MemByte),
    .M_MemHalf(M_MemHalf), .M_MemSignExtend(M_MemSignExtend),
    .M_Address(M_Address), .M_WriteData(M_WriteData), .M_Flush(M_Flush),
    .M_StallIn(M_StallIn), .M_LLSC(M_LLSC), .M_Eret(M_Eret),
    .DataMem_Ready(DataMem_Ready), .DataMem_In(DataMem_In),
    .DataMem_Read(DataMem_Read), .DataMem_Write(DataMem_Write),
    .DataMem_Address(DataMem_Address), .DataMem_Out(DataMem_Out),
    .M_ReadData(M_ReadData), .M_MemStall(M_MemStall),
    .M_Exc_AdEL(M_Exc_AdEL), .M_Exc_AdES(M_Exc_AdES)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd, wr, byt, half, sgn, flush, llsc;
    logic [31:0] addr, wdata, din;
    int          waits;       // 0 = no bus access expected
    logic [3:0]  exp_write;
    logic [31:0] exp_out, exp_addr, exp_rdata;
    logic        exp_adel, exp_ades;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, wr, byt, half, sgn, flush,
                              input logic [31:0] addr, wdata, din, input int waits,
                              input logic [3:0] ew, input logic [31:0] eo, ea, er,
                              input logic adel, ades);
    vec_t v;
    v.rd = rd; v.wr = wr; v.byt = byt; v.half = half; v.sgn = sgn; v.flush = flush;
    v.llsc = 1'b0; v.addr = addr; v.wdata = wdata; v.din = din; v.waits = waits;
    v.exp_write = ew; v.exp_out = eo; v.exp_addr = ea; v.exp_rdata = er;
    v.exp_adel = adel; v.exp_ades = ades;
    return v;
  endfunction

  task automatic clear_inputs();
    M_MemRead = 0; M_MemWrite = 0; M_MemByte = 0; M_MemHalf = 0; M_MemSignExtend = 0;
    M_Address = 0; M_WriteData = 0; M_Flush = 0; M_LLSC = 0; M_Eret = 0;
    DataMem_Ready = 0; DataMem_In = 0;
  endtask

  // Called just after a rising edge; returns just after a rising edge with the instruction advanced.
  task automatic apply_vec(input string nm, input vec_t v);
    int stall_cnt;
    int read_cnt;
    M_MemRead = v.rd; M_MemWrite = v.wr; M_MemByte = v.byt; M_MemHalf = v.half;
    M_MemSignExtend = v.sgn; M_Flush = v.flush; M_LLSC = v.llsc;
    M_Address = v.addr; M_WriteData = v.wdata; DataMem_Ready = 0;
    @(negedge clock);
    check({nm, "_adel"}, 32'(M_Exc_AdEL), 32'(v.exp_adel));
    check({nm, "_ades"}, 32'(M_Exc_AdES), 32'(v.exp_ades));
    if (v.waits == 0) begin
      check({nm, "_stall"}, 32'(M_MemStall), 32'd0);
      @(posedge clock); #1;
      @(negedge clock);
      check({nm, "_noread"}, 32'(DataMem_Read), 32'd0);
      check({nm, "_nowrite"}, 32'(DataMem_Write), 32'd0);
      @(posedge clock); #1;
    end else begin
      stall_cnt = int'(M_MemStall);
      read_cnt  = 0;
      for (int n = 1; n <= v.waits; n++) begin
        @(posedge clock); #1;
        if (n == v.waits) begin
          DataMem_Ready = 1; DataMem_In = v.din;
        end
        @(negedge clock);
        stall_cnt += int'(M_MemStall);
        read_cnt  += int'(DataMem_Read);
        check($sformatf("%s_write%0d", nm, n), 32'(DataMem_Write), 32'(v.exp_write));
        check($sformatf("%s_addr%0d", nm, n), 32'(DataMem_Address), v.exp_addr);
        if (v.wr) check($sformatf("%s_out%0d", nm, n), DataMem_Out, v.exp_out);
      end
      @(posedge clock); #1;
      DataMem_Ready = 0; DataMem_In = 32'h5555_AAAA;
      @(negedge clock);
      check({nm, "_done_stall"}, 32'(M_MemStall), 32'd0);
      check({nm, "_done_read"}, 32'(DataMem_Read), 32'd0);
      check({nm, "_done_write"}, 32'(DataMem_Write), 32'd0);
      check({nm, "_rdata"}, M_ReadData, v.exp_rdata);
      check({nm, "_stallcycles"}, 32'(stall_cnt), 32'(v.waits + 1));
      check({nm, "_readcycles"}, 32'(read_cnt), v.rd ? 32'(v.waits) : 32'd0);
      @(posedge clock); #1;
    end
  endtask

  vec_t vecs[17];
  vec_t sv;
  int   held_reads;

  initial begin
    //              rd wr by hf sg fl addr         wdata         din           W  wr       out           waddr  rdata         el es
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 32'h100, 32'h0,         32'hDEADBEEF, 3, 4'b0000, 32'h0,        32'h40, 32'hDEADBEEF, 0, 0);
    vecs[1]  = mk(1, 0, 1, 0, 1, 0, 32'h101, 32'h0,         32'h12803456, 1, 4'b0000, 32'h0,        32'h40, 32'hFFFFFF80, 0, 0);
    vecs[2]  = mk(1, 0, 1, 0, 0, 0, 32'h101, 32'h0,         32'h12803456, 1, 4'b0000, 32'h0,        32'h40, 32'h00000080, 0, 0);
    vecs[3]  = mk(1, 0, 0, 1, 1, 0, 32'h102, 32'h0,         32'h12348765, 2, 4'b0000, 32'h0,        32'h40, 32'hFFFF8765, 0, 0);
    vecs[4]  = mk(1, 0, 0, 1, 0, 0, 32'h100, 32'h0,         32'h87651234, 1, 4'b0000, 32'h0,        32'h40, 32'h00008765, 0, 0);
    vecs[5]  = mk(1, 0, 1, 0, 1, 0, 32'h103, 32'h0,         32'h0000007F, 1, 4'b0000, 32'h0,        32'h40, 32'h0000007F, 0, 0);
    vecs[6]  = mk(0, 1, 0, 1, 0, 0, 32'h102, 32'h0000ABCD,  32'h0,        1, 4'b0011, 32'hABCDABCD, 32'h40, 32'h0000007F, 0, 0);
    vecs[7]  = mk(0, 1, 1, 0, 0, 0, 32'h100, 32'h0000005A,  32'h0,        2, 4'b1000, 32'h5A5A5A5A, 32'h40, 32'h0000007F, 0, 0);
    vecs[8]  = mk(0, 1, 1, 0, 0, 0, 32'h103, 32'h000000C3,  32'h0,        1, 4'b0001, 32'hC3C3C3C3, 32'h40, 32'h0000007F, 0, 0);
    vecs[9]  = mk(0, 1, 0, 0, 0, 0, 32'h204, 32'hCAFEF00D,  32'h0,        1, 4'b1111, 32'hCAFEF00D, 32'h81, 32'h0000007F, 0, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 32'h103, 32'h0,         32'h0,        0, 4'b0000, 32'h0,        32'h0,  32'h0,        1, 0);
    vecs[11] = mk(1, 0, 0, 0, 0, 1, 32'h103, 32'h0,         32'h0,        0, 4'b0000, 32'h0,        32'h0,  32'h0,        0, 0);
    vecs[12] = mk(0, 1, 0, 1, 0, 0, 32'h101, 32'h0,         32'h0,        0, 4'b0000, 32'h0,        32'h0,  32'h0,        0, 1);
    vecs[13] = mk(0, 1, 0, 0, 0, 0, 32'h102, 32'h0,         32'h0,        0, 4'b0000, 32'h0,        32'h0,  32'h0,        0, 1);
    vecs[14] = mk(1, 0, 0, 1, 0, 0, 32'h103, 32'h0,         32'h0,        0, 4'b0000, 32'h0,        32'h0,  32'h0,        1, 0);
    vecs[15] = mk(0, 1, 0, 0, 0, 1, 32'h100, 32'h11111111,  32'h0,        0, 4'b0000, 32'h0,        32'h0,  32'h0,        0, 0);
    vecs[16] = mk(1, 0, 1, 0, 0, 0, 32'h102, 32'h0,         32'h0000F100, 1, 4'b0000, 32'h0,        32'h40, 32'h000000F1, 0, 0);

    clear_inputs();
    M_StallIn = 0;
    reset = 0;
    #1 reset = 1;
    #2;
    check("rst_read",  32'(DataMem_Read), 32'd0);
    check("rst_write", 32'(DataMem_Write), 32'd0);
    check("rst_addr",  32'(DataMem_Address), 32'd0);
    check("rst_out",   DataMem_Out, 32'd0);
    check("rst_rdata", M_ReadData, 32'd0);
    check("rst_stall", 32'(M_MemStall), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    @(posedge clock); #1;

    // Table: back-to-back accesses, each starting on the edge the previous one advanced.
    for (int i = 0; i < 17; i++)
      apply_vec($sformatf("v%0d", i), vecs[i]);
    clear_inputs();

    // Ready arrives while MEM is held: result stays in DONE, bus is not re-used.
    M_StallIn = 1; M_MemRead = 1; M_Address = 32'h300;
    held_reads = 0;
    @(negedge clock);
    check("hold_stall_idle", 32'(M_MemStall), 32'd1);
    @(posedge clock); #1;
    DataMem_Ready = 1; DataMem_In = 32'h11223344;
    @(negedge clock);
    held_reads += int'(DataMem_Read);
    @(posedge clock); #1;
    DataMem_Ready = 0; DataMem_In = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      held_reads += int'(DataMem_Read);
      check($sformatf("hold_stall%0d", k), 32'(M_MemStall), 32'd0);
      check($sformatf("hold_rdata%0d", k), M_ReadData, 32'h11223344);
      @(posedge clock); #1;
    end
    M_StallIn = 0;
    @(negedge clock);
    held_reads += int'(DataMem_Read);
    @(posedge clock); #1;
    clear_inputs();
    @(negedge clock);
    held_reads += int'(DataMem_Read);
    check("hold_single_access", 32'(held_reads), 32'd1);
    check("hold_after_stall", 32'(M_MemStall), 32'd0);
    @(posedge clock); #1;

`ifdef MEM_LLSC_EN
    // LL then SC to the same word succeeds.
    sv = mk(1, 0, 0, 0, 0, 0, 32'h200, 32'h0, 32'h77777777, 1, 4'b0000, 32'h0, 32'h80, 32'h77777777, 0, 0);
    sv.llsc = 1; apply_vec("ll1", sv);
    sv = mk(0, 1, 0, 0, 0, 0, 32'h200, 32'h12345678, 32'h0, 1, 4'b1111, 32'h12345678, 32'h80, 32'h1, 0, 0);
    sv.llsc = 1; apply_vec("sc1", sv);
    // LL, ERET, SC: SC fails with no bus access and no stall.
    sv = mk(1, 0, 0, 0, 0, 0, 32'h200, 32'h0, 32'h66666666, 1, 4'b0000, 32'h0, 32'h80, 32'h66666666, 0, 0);
    sv.llsc = 1; apply_vec("ll2", sv);
    clear_inputs();
    M_Eret = 1;
    @(posedge clock); #1;
    M_Eret = 0;
    M_MemWrite = 1; M_LLSC = 1; M_Address = 32'h200; M_WriteData = 32'h99999999;
    @(negedge clock);
    check("scf_stall", 32'(M_MemStall), 32'd0);
    check("scf_rdata", M_ReadData, 32'd0);
    @(posedge clock); #1;
    clear_inputs();
    @(negedge clock);
    check("scf_nowrite", 32'(DataMem_Write), 32'd0);
    @(posedge clock); #1;
`else
    // Without LL/SC support an SC is a plain SW: write happens, load result untouched.
    sv = mk(0, 1, 0, 0, 0, 0, 32'h200, 32'h12345678, 32'h0, 1, 4'b1111, 32'h12345678, 32'h80, 32'h11223344, 0, 0);
    sv.llsc = 1; apply_vec("sc_plain", sv);
    clear_inputs();
`endif

    // Reset asserted mid-WAIT: strobes drop at once, a new access runs after release.
    M_MemWrite = 1; M_Address = 32'h100; M_WriteData = 32'h11111111;
    @(negedge clock);
    @(posedge clock); #1;
    check("rstw_write_before", 32'(DataMem_Write), 32'b1111);
    #2 reset = 1;
    #1;
    check("rstw_write", 32'(DataMem_Write), 32'd0);
    check("rstw_read", 32'(DataMem_Read), 32'd0);
    check("rstw_addr", 32'(DataMem_Address), 32'd0);
    check("rstw_rdata", M_ReadData, 32'd0);
    clear_inputs();
    M_MemRead = 1; M_Address = 32'h104;
    @(negedge clock);
    reset = 0;
    check("rstw_idle_stall", 32'(M_MemStall), 32'd1);
    check("rstw_idle_read", 32'(DataMem_Read), 32'd0);
    @(posedge clock); #1;
    check("rstw_reissue_read", 32'(DataMem_Read), 32'd1);
    check("rstw_reissue_addr", 32'(DataMem_Address), 32'h41);
    DataMem_Ready = 1; DataMem_In = 32'h0BADF00D;
    @(posedge clock); #1;
    DataMem_Ready = 0;
    @(negedge clock);
    check("rstw_rdata_after", M_ReadData, 32'h0BADF00D);
    check("rstw_stall_after", 32'(M_MemStall), 32'd0);
    @(posedge clock); #1;
    clear_inputs();
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
